// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: shared miss handler and memory port for the split I/D caches.
// Forwards write-through stores to memory from IDLE. On a miss it fetches one
// whole block into the missing cache and stalls the CPU until the block is in.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no miss in service; forwards stores, D miss wins over I miss
// FILL  | issuing block reads, one word per cycle, and accepting returned data
// DRAIN | all reads issued; waiting for the remaining data words to return
module cache_fill_ctrl #(
    parameter int BLK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_i,
    input  logic        miss_d,
    input  logic [15:0] addr_i,
    input  logic [15:0] addr_d,
    input  logic        wr_req,
    input  logic [15:0] wr_data,
    input  logic [15:0] mem_rdata,
    input  logic        mem_vld,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] fill_data,
    output logic [15:0] fill_addr,
    output logic        i_data_we,
    output logic        i_meta_we,
    output logic        d_data_we,
    output logic        d_meta_we,
    output logic        stall,
    output logic        idle
);
    localparam int CW = $clog2(BLK_WORDS);
    localparam logic [CW-1:0] LAST = CW'(BLK_WORDS - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    // Block is BLK_WORDS 16-bit words, so the byte offset field is CW+1 bits.
    localparam logic [15:0] BASE_MASK = ~16'((2 * BLK_WORDS) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_base;
    logic [15:0]   w_base_nxt;
    logic          r_tgt;
    logic          w_tgt_nxt;
    logic [CW-1:0] r_iss_cnt;
    logic [CW-1:0] w_iss_nxt;
    logic [CW-1:0] r_rcv_cnt;
    logic [CW-1:0] w_rcv_nxt;
    logic          w_busy;
    logic          w_vld_take;
    logic          w_last_rcv;
    logic [15:0]   w_iss_addr;

    // Returned data only counts while a fill is active; stale words after an
    // aborting reset land in IDLE and are dropped here.
    assign w_busy     = (r_state != ST_IDLE);
    assign w_vld_take = mem_vld & w_busy & ~rst;
    assign w_last_rcv = w_vld_take & (r_rcv_cnt == LAST);
    assign w_iss_addr = r_base | 16'({r_iss_cnt, 1'b0});

    // State and fill bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_tgt     <= 1'b0;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_base    <= w_base_nxt;
            r_tgt     <= w_tgt_nxt;
            r_iss_cnt <= w_iss_nxt;
            r_rcv_cnt <= w_rcv_nxt;
        end
    end

    // Next-state decode and memory request drive.
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_tgt_nxt   = r_tgt;
        w_iss_nxt   = r_iss_cnt;
        w_rcv_nxt   = r_rcv_cnt;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;

        if (w_vld_take) begin
            w_rcv_nxt = r_rcv_cnt + ONE;
        end

        unique case (r_state)
            ST_IDLE: begin
                // A store always goes first; a pending miss waits one cycle.
                if (wr_req) begin
                    mem_en   = 1'b1;
                    mem_wr   = 1'b1;
                    mem_addr = addr_d;
                end else if (miss_d) begin
                    w_base_nxt  = addr_d & BASE_MASK;
                    w_tgt_nxt   = 1'b1;
                    w_iss_nxt   = '0;
                    w_rcv_nxt   = '0;
                    w_state_nxt = ST_FILL;
                end else if (miss_i) begin
                    w_base_nxt  = addr_i & BASE_MASK;
                    w_tgt_nxt   = 1'b0;
                    w_iss_nxt   = '0;
                    w_rcv_nxt   = '0;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_en    = 1'b1;
                mem_addr  = w_iss_addr;
                w_iss_nxt = r_iss_cnt + ONE;
                if (w_last_rcv) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_iss_cnt == LAST) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_rcv) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Nothing reaches memory while reset is held, even mid-fill.
        if (rst) begin
            mem_en   = 1'b0;
            mem_wr   = 1'b0;
            mem_addr = '0;
        end
    end

    assign mem_wdata = wr_data;
    assign fill_data = mem_rdata;
    assign fill_addr = r_base | 16'({r_rcv_cnt, 1'b0});
    assign i_data_we = w_vld_take & ~r_tgt;
    assign d_data_we = w_vld_take & r_tgt;
    assign i_meta_we = w_last_rcv & ~r_tgt;
    assign d_meta_we = w_last_rcv & r_tgt;
    assign idle      = (r_state == ST_IDLE);
    assign stall     = ~idle | miss_i | miss_d;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: a memory model returns word=address,
// expected cache writes are queued at stimulus time and popped by a monitor.
module tb_cache_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        miss_i;
    logic        miss_d;
    logic [15:0] addr_i;
    logic [15:0] addr_d;
    logic        wr_req;
    logic [15:0] wr_data;
    logic [15:0] mem_rdata;
    logic        mem_vld;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] fill_data;
    logic [15:0] fill_addr;
    logic        i_data_we;
    logic        i_meta_we;
    logic        d_data_we;
    logic        d_meta_we;
    logic        stall;
    logic        idle;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_mode = 0;
    int last_due = 0;

    typedef struct {
        logic        tgt;
        logic [15:0] addr;
        logic        meta;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];

    cache_fill_ctrl #(.BLK_WORDS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .miss_i    (miss_i),
        .miss_d    (miss_d),
        .addr_i    (addr_i),
        .addr_d    (addr_d),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .mem_rdata (mem_rdata),
        .mem_vld   (mem_vld),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .fill_data (fill_data),
        .fill_addr (fill_addr),
        .i_data_we (i_data_we),
        .i_meta_we (i_meta_we),
        .d_data_we (d_data_we),
        .d_meta_we (d_meta_we),
        .stall     (stall),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_block(input logic tgt, input logic [15:0] base);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.tgt  = tgt;
            e.addr = base + 16'(2 * k);
            e.meta = (k == 7);
            exp_q.push_back(e);
        end
    endtask

    // Wait (bounded) for the meta write of one cache, counting stall cycles,
    // then drop that miss at the start of the next cycle as a cache hit would.
    task automatic wait_meta(input logic is_d, inout int scnt);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (stall) scnt++;
            if (is_d ? d_meta_we : i_meta_we) seen = 1'b1;
        end
        check("meta_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        if (is_d) miss_d = 1'b0;
        else      miss_i = 1'b0;
    endtask

    // Memory model: read requests sampled mid-cycle, answered in order.
    initial begin
        int lat;
        int due;
        rd_t r;
        forever begin
            @(negedge clk);
            if (mem_en && !mem_wr) begin
                lat = (lat_mode != 0) ? int'($urandom_range(1, 6)) : 4;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                r.addr = mem_addr;
                r.due  = due;
                rd_q.push_back(r);
            end
        end
    end

    // Memory data return, driven just after each rising edge.
    initial begin
        mem_vld   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                mem_vld   = 1'b1;
                mem_rdata = rd_q[0].addr;
                void'(rd_q.pop_front());
            end else begin
                mem_vld   = 1'b0;
                mem_rdata = 16'h0000;
            end
        end
    end

    // Monitor: every cache write is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (idle && !wr_req) check("mem_en_idle", 32'(mem_en), 32'd0);
            if (i_data_we || d_data_we || i_meta_we || d_meta_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: got i=%b/%b d=%b/%b addr %h expected none",
                             i_data_we, i_meta_we, d_data_we, d_meta_we, fill_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("we_tgt", {30'd0, d_data_we, i_data_we}, e.tgt ? 32'd2 : 32'd1);
                    check("fill_addr", 32'(fill_addr), 32'(e.addr));
                    check("fill_data", 32'(fill_data), 32'(e.addr));
                    check("meta_we", {30'd0, d_meta_we, i_meta_we},
                          e.meta ? (e.tgt ? 32'd2 : 32'd1) : 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int scnt;
        rst = 1'b1; miss_i = 1'b0; miss_d = 1'b0;
        addr_i = '0; addr_d = '0; wr_req = 1'b0; wr_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_we", {28'd0, i_data_we, i_meta_we, d_data_we, d_meta_we}, 32'd0);
        @(posedge clk); #1;
        miss_d = 1'b1;
        @(negedge clk);
        check("rst_stall_miss", 32'(stall), 32'd1);
        @(posedge clk); #1;
        miss_d = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single D miss: block 0x1230, 13 stall cycles
        addr_d = 16'h1234; miss_d = 1'b1;
        push_block(1'b1, 16'h1230);
        scnt = 0;
        wait_meta(1'b1, scnt);
        check("d_stall_cycles", 32'(scnt), 32'd13);
        @(negedge clk);
        check("d_done_idle", 32'(idle), 32'd1);
        check("d_done_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        // Simultaneous misses: D block 0x8000 first, then I block 0x0040
        addr_i = 16'h0040; addr_d = 16'h8008; miss_i = 1'b1; miss_d = 1'b1;
        push_block(1'b1, 16'h8000);
        push_block(1'b0, 16'h0040);
        scnt = 0;
        wait_meta(1'b1, scnt);
        wait_meta(1'b0, scnt);
        check("both_stall_cycles", 32'(scnt), 32'd26);
        check("both_q_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Store in IDLE
        addr_d = 16'h2002; wr_data = 16'hBEEF; wr_req = 1'b1;
        @(negedge clk);
        check("st_mem_en", 32'(mem_en), 32'd1);
        check("st_mem_wr", 32'(mem_wr), 32'd1);
        check("st_mem_addr", 32'(mem_addr), 32'h2002);
        check("st_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("st_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        wr_req = 1'b0;

        // Store plus D miss: write goes out first, then the fill
        addr_d = 16'h3456; wr_data = 16'h1357; wr_req = 1'b1; miss_d = 1'b1;
        push_block(1'b1, 16'h3450);
        @(negedge clk);
        check("stm_mem_wr", 32'(mem_wr), 32'd1);
        check("stm_mem_addr", 32'(mem_addr), 32'h3456);
        check("stm_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        check("stm_no_rewrite", 32'(mem_wr), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Store requested during the fill is ignored
        wr_req = 1'b1;
        @(negedge clk);
        check("fill_wr_ignored", 32'(mem_wr), 32'd0);
        check("fill_rd_issue", 32'(mem_en), 32'd1);
        @(posedge clk); #1;
        wr_req = 1'b0;
        scnt = 0;
        wait_meta(1'b1, scnt);
        check("stm_q_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Reset at cycle 6 of a fill; late data must not reach the cache
        addr_d = 16'h5000; miss_d = 1'b1;
        push_block(1'b1, 16'h5000);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1; miss_d = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 50 && rd_q.size() > 0; k++) @(posedge clk);
        check("abort_mem_drained", 32'(rd_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_idle", 32'(idle), 32'd1);
        check("abort_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        // Fresh I miss with variable memory latency 1..6
        lat_mode = 1;
        addr_i = 16'h7A5C; miss_i = 1'b1;
        push_block(1'b0, 16'h7A50);
        scnt = 0;
        wait_meta(1'b0, scnt);
        check("var_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("var_idle", 32'(idle), 32'd1);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

This block is the shared miss-handling and memory-interface controller for the split I/D caches. It sits between the two cache arrays and the 4-cycle pipelined main memory. It serialises write-through stores into memory and services cache misses by fetching whole 16-byte blocks (8 words) into the missing cache. While any miss is outstanding it stalls the CPU.

## Interface
Parameters:
- BLK_WORDS, 8, words per cache block (16-bit words, 16-byte blocks); counters are log2(BLK_WORDS) bits wide.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_i  in  1  I-cache tag miss for the current fetch address.
- miss_d  in  1  D-cache tag miss for the current load/store address.
- addr_i  in  16  I-cache CPU byte address.
- addr_d  in  16  D-cache CPU byte address.
- wr_req  in  1  store in progress; write-through to memory is requested.
- wr_data  in  16  store data.
- mem_rdata  in  16  memory read data.
- mem_vld  in  1  memory read data valid.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data; equals wr_data.
- fill_data  out  16  block word being written to a cache; equals mem_rdata.
- fill_addr  out  16  byte address of fill_data.
- i_data_we  out  1  I-cache data-array write pulse.
- i_meta_we  out  1  I-cache tag/valid write pulse.
- d_data_we  out  1  D-cache data-array write pulse.
- d_meta_we  out  1  D-cache tag/valid write pulse.
- stall  out  1  CPU pipeline stall.
- idle  out  1  FSM is in IDLE.

## Operation
States: IDLE, FILL, DRAIN.

Registers:
- base[15:0]: block base address, the missing address with bits [3:0] cleared.
- tgt: 0 selects the I-cache, 1 selects the D-cache.
- iss_cnt[2:0]: words issued.
- rcv_cnt[2:0]: words received.

IDLE:
- wr_req=1 has top priority. Drive mem_en=1, mem_wr=1, mem_addr=addr_d, mem_wdata=wr_data combinationally. Stay in IDLE. Any miss is taken on the next cycle.
- Otherwise miss_d=1: latch base={addr_d[15:4],4'h0} and tgt=D, clear both counters, go to FILL.
- Otherwise miss_i=1: latch base from addr_i, tgt=I, go to FILL. When both miss together, D is served first and I next.

FILL:
- Each cycle drive mem_en=1, mem_wr=0, mem_addr=base|{iss_cnt,1'b0}, then iss_cnt++.
- After issuing word 7, go to DRAIN.

FILL and DRAIN, on each mem_vld:
- Pulse the tgt cache's data_we for one cycle with fill_addr=base|{rcv_cnt,1'b0}, then rcv_cnt++.
- On the mem_vld with rcv_cnt==7, also pulse the tgt meta_we in the same cycle.

DRAIN:
- mem_en=0.
- Leave for IDLE on the cycle after the 8th mem_vld.
- Completion from FILL is also legal if all 8 words arrive before issue ends.

Counting and widths:
- Completion is counted by mem_vld, not by cycles, so any memory latency of 1 or more works.
- Counters wrap modulo 8 but are never used past 7.

Other rules:
- mem_vld in IDLE is ignored: no WE pulses.
- wr_req in FILL/DRAIN is ignored. The CPU is stalled and holds it.
- stall = !idle | miss_i | miss_d (combinational), so stall is high in the cycle the miss is first seen.
- Reset mid-fill forces IDLE and clears the counters. Late mem_vld from the aborted fill produces no WE pulses.

## Timing
- Reset values: state=IDLE, base=0, counters=0, tgt=I. All WE outputs=0, mem_en=0, mem_wr=0, mem_addr=0, stall=miss_i|miss_d, idle=1.
- With a 4-cycle memory and the miss first seen at cycle 0 in IDLE:
  - Reads are issued at cycles 1–8.
  - mem_vld arrives at cycles 5–12.
  - meta_we pulses at cycle 12.
  - IDLE at cycle 13.
  - The cache reports a hit at cycle 13 and stall drops.
  - Miss penalty: 13 cycles.
- A back-to-back second miss (the other cache) starts FILL at cycle 14.
- Data and meta WE pulses are exactly one cycle wide and coincide with mem_vld. fill_data is valid only in that cycle.
- mem_en is never high in DRAIN or in IDLE without wr_req.

## Test plan
- Reset: assert rst for 2 cycles with miss inputs low -> idle=1, stall=0, all WEs=0, mem_en=0.
- D miss: miss_d with addr_d=0x1234, memory preloaded with word=addr -> reads issued at 0x1230,0x1232…0x123E. Eight d_data_we pulses carry fill_addr=data=0x1230…0x123E. d_meta_we pulses with the 8th. No i_* pulses. Total stall 13 cycles.
- Simultaneous misses: miss_i with addr_i=0x0040 and miss_d with addr_d=0x8008 -> D block 0x8000 filled first, then I block 0x0040. Exactly 8 pulses per cache.
- Store: wr_req with addr_d=0x2002, wr_data=0xBEEF in IDLE -> same cycle mem_en=1, mem_wr=1, mem_addr=0x2002, mem_wdata=0xBEEF. stall=0 when there is no miss.
- Store plus miss: wr_req and miss_d in the same cycle -> write issued first, FILL begins next cycle.
- Reset mid-fill: assert rst at cycle 6 of a fill and keep mem_vld pulsing -> no WE pulses after reset, idle=1. A fresh miss then fills correctly. A variable-latency memory model with 1–6 cycles per word still yields exactly 8 in-order writes.
